// File: rtl/slot_timer_arbiter_pkg.sv
// Shared types and helpers for the slot timer arbiter: FSM states, default
// counter width and the round-robin winner search.
package slot_arb_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CNT_W_DEFAULT = 5;

  // Search upward from ptr with wrap at 8. Requests are zero-extended to
  // 8 bits, so empty upper bits make this equal to wrapping at NUM_REQ.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
    logic [2:0] win;
    logic [2:0] idx;
    logic       found;
    win   = ptr;
    found = 1'b0;
    for (int off = 0; off < 8; off++) begin
      idx = ptr + 3'(off);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/slot_timer_arbiter_if.sv
// Requester-side bus of the slot timer arbiter. The aborted signal exists
// only when SLOT_ARB_ABORT_EN is defined.
interface slot_timer_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = slot_arb_pkg::CNT_W_DEFAULT
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] len;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic [CNT_W-1:0]         cnt_out;
  logic                     done;
  logic [ID_W-1:0]          done_id;
`ifdef SLOT_ARB_ABORT_EN
  logic                     aborted;

  modport master (output req, len,
                  input  grant, busy, cnt_out, done, done_id, aborted);
  modport slave  (input  req, len,
                  output grant, busy, cnt_out, done, done_id, aborted);
`else
  modport master (output req, len,
                  input  grant, busy, cnt_out, done, done_id);
  modport slave  (input  req, len,
                  output grant, busy, cnt_out, done, done_id);
`endif

endinterface

// File: rtl/slot_timer_arbiter_counter.sv
// Loadable, enable-gated down counter that saturates at zero; the shared
// countdown datapath handed out by the slot timer arbiter.
module loadable_down_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] out,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/slot_timer_arbiter.sv
// Round-robin time-slot arbiter for one shared down counter. Define
// SLOT_ARB_ABORT_EN to end a slot early when its requester drops req.
module slot_timer_arbiter
  import slot_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  slot_timer_arbiter_if.slave  bus
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    winner_q, winner_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ID_W-1:0]    done_id_q, done_id_d;
`ifdef SLOT_ARB_ABORT_EN
  logic               aborted_q, aborted_d;
`endif

  logic [ID_W-1:0]    pick;
  logic [CNT_W-1:0]   len_sel;
  logic [CNT_W-1:0]   cnt_val;
  logic               cnt_zero;
  logic               load;
  logic               en;
  logic               abort_now;

  assign pick    = ID_W'(rr_pick(8'(bus.req), 3'(rr_ptr_q)));
  assign len_sel = bus.len[pick*CNT_W +: CNT_W];

  loadable_down_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (len_sel),
    .en       (en),
    .out      (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
`ifdef SLOT_ARB_ABORT_EN
    aborted_d = 1'b0;
    abort_now = !bus.req[winner_q];
`else
    abort_now = 1'b0;
`endif
    load      = 1'b0;
    en        = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (|bus.req) begin
          state_d  = RUN;
          winner_d = pick;
          grant_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
          busy_d   = 1'b1;
          load     = 1'b1;
        end
      end
      RUN: begin
        // Done is registered, so it is raised on the way into DONE.
        if (cnt_zero || abort_now) begin
          state_d   = DONE;
          grant_d   = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          done_id_d = winner_q;
`ifdef SLOT_ARB_ABORT_EN
          aborted_d = abort_now;
`endif
        end else begin
          en = 1'b1;
        end
      end
      DONE: begin
        rr_ptr_d = (winner_q == ID_W'(NUM_REQ-1)) ? '0 : winner_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      winner_q  <= '0;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
`ifdef SLOT_ARB_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
`ifdef SLOT_ARB_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.cnt_out = cnt_val;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
`ifdef SLOT_ARB_ABORT_EN
  assign bus.aborted = aborted_q;
`endif

endmodule

// File: tb/tb_slot_timer_arbiter.sv
// Self-checking bench for slot_timer_arbiter: directed scenarios plus a
// randomized run against a slot-level reference model.
module tb_slot_timer_arbiter;

  localparam int N = 4;
  localparam int W = 5;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  slot_timer_arbiter_if #(.NUM_REQ(N), .CNT_W(W)) bus ();

  slot_timer_arbiter #(.NUM_REQ(N), .CNT_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: phase 0 = waiting, 1 = slot active, 2 = completion cycle
  int         m_ph, m_win, m_ptr;
  logic [3:0] m_grant;
  logic       m_busy, m_done, m_ab;
  logic [4:0] m_cnt;
  logic [1:0] m_did;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int i, input logic [4:0] v);
    bus.len[i*W +: W] = v;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic m_step();
    int w;
    bit ab;
    if (reset) begin
      m_ph = 0; m_ptr = 0; m_win = 0;
      m_grant = '0; m_busy = 0; m_cnt = '0; m_done = 0; m_did = '0; m_ab = 0;
      return;
    end
    m_done = 0;
    m_ab   = 0;
    if (m_ph == 0) begin
      m_grant = '0;
      m_busy  = 0;
      w = -1;
      for (int off = 0; off < N; off++)
        if (w < 0 && bus.req[(m_ptr + off) % N]) w = (m_ptr + off) % N;
      if (w >= 0) begin
        m_win   = w;
        m_cnt   = bus.len[w*W +: W];
        m_grant = 4'(1 << w);
        m_busy  = 1;
        m_ph    = 1;
      end
    end else if (m_ph == 1) begin
      ab = 0;
`ifdef SLOT_ARB_ABORT_EN
      ab = !bus.req[m_win];
`endif
      if (ab || m_cnt == 0) begin
        m_ph = 2; m_done = 1; m_ab = ab; m_did = 2'(m_win);
        m_grant = '0; m_busy = 0;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end else begin
      m_ptr = (m_win + 1) % N;
      m_ph  = 0;
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    bus.req = '0;
    bus.len = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_tests++;
      if ({bus.grant, bus.busy, bus.cnt_out, bus.done, bus.done_id} !== 13'd0) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d grant=%b busy=%b cnt=%0d done=%b id=%0d required all zero",
                 c, bus.grant, bus.busy, bus.cnt_out, bus.done, bus.done_id);
      end
    end
  endtask

  task automatic test_single();
    int exp_cnt;
    do_reset();
    set_len(1, 5'd3);
    bus.req = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      tick();
      exp_cnt = 3 - c;
      n_tests++;
      if (bus.grant !== 4'b0010 || bus.busy !== 1'b1 || bus.cnt_out !== 5'(exp_cnt) || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL single_run cyc=%0d grant=%b busy=%b cnt=%0d done=%b required grant=0010 busy=1 cnt=%0d done=0",
                 c, bus.grant, bus.busy, bus.cnt_out, bus.done, exp_cnt);
      end
    end
    tick();
    n_tests++;
    if (bus.done !== 1'b1 || bus.done_id !== 2'd1 || bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done done=%b id=%0d grant=%b busy=%b required done=1 id=1 grant=0000 busy=0",
               bus.done, bus.done_id, bus.grant, bus.busy);
    end
    bus.req = '0;
    tick();
    n_tests++;
    if (bus.grant !== 4'b0000 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after grant=%b done=%b required grant=0000 done=0", bus.grant, bus.done);
    end
  endtask

  task automatic test_round_robin();
    int id;
    do_reset();
    for (int i = 0; i < N; i++) set_len(i, 5'd1);
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      id = g % N;
      for (int c = 0; c < 2; c++) begin
        tick();
        n_tests++;
        if (bus.grant !== 4'(1 << id) || bus.cnt_out !== 5'(1 - c)) begin
          n_fail++;
          $display("FAIL rr_grant g=%0d cyc=%0d grant=%b cnt=%0d required grant=%b cnt=%0d",
                   g, c, bus.grant, bus.cnt_out, 4'(1 << id), 1 - c);
        end
      end
      tick();
      n_tests++;
      if (bus.done !== 1'b1 || bus.done_id !== 2'(id) || bus.grant !== 4'b0000) begin
        n_fail++;
        $display("FAIL rr_done g=%0d done=%b id=%0d grant=%b required done=1 id=%0d grant=0000",
                 g, bus.done, bus.done_id, bus.grant, id);
      end
      if (g == 4) bus.req = '0;
      tick();
      n_tests++;
      if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_gap g=%0d grant=%b busy=%b done=%b required grant=0000 busy=0 done=0",
                 g, bus.grant, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_zero_wrap();
    do_reset();
    set_len(2, 5'd0);
    set_len(3, 5'd0);
    set_len(0, 5'd2);
    bus.req = 4'b0100;
    tick();
    n_tests++;
    if (bus.grant !== 4'b0100 || bus.cnt_out !== 5'd0) begin
      n_fail++;
      $display("FAIL zw_grant2 grant=%b cnt=%0d required grant=0100 cnt=0", bus.grant, bus.cnt_out);
    end
    tick();
    bus.req = 4'b1001;
    n_tests++;
    if (bus.done !== 1'b1 || bus.done_id !== 2'd2) begin
      n_fail++;
      $display("FAIL zw_done2 done=%b id=%0d required done=1 id=2", bus.done, bus.done_id);
    end
    tick();
    tick();
    n_tests++;
    if (bus.grant !== 4'b1000 || bus.busy !== 1'b1 || bus.cnt_out !== 5'd0) begin
      n_fail++;
      $display("FAIL zw_grant3 grant=%b busy=%b cnt=%0d required grant=1000 busy=1 cnt=0",
               bus.grant, bus.busy, bus.cnt_out);
    end
    tick();
    n_tests++;
    if (bus.done !== 1'b1 || bus.done_id !== 2'd3 || bus.grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL zw_done3 done=%b id=%0d grant=%b required done=1 id=3 grant=0000",
               bus.done, bus.done_id, bus.grant);
    end
    tick();
    tick();
    n_tests++;
    if (bus.grant !== 4'b0001 || bus.cnt_out !== 5'd2) begin
      n_fail++;
      $display("FAIL zw_wrap0 grant=%b cnt=%0d required grant=0001 cnt=2", bus.grant, bus.cnt_out);
    end
    bus.req = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_len(2, 5'd20);
    set_len(1, 5'd4);
    bus.req = 4'b0100;
    for (int c = 0; c < 9; c++) tick();
    n_tests++;
    if (bus.grant !== 4'b0100 || bus.cnt_out !== 5'd12) begin
      n_fail++;
      $display("FAIL rm_before grant=%b cnt=%0d required grant=0100 cnt=12", bus.grant, bus.cnt_out);
    end
    reset = 1'b1;
    tick();
    n_tests++;
    if ({bus.grant, bus.busy, bus.cnt_out, bus.done, bus.done_id} !== 13'd0) begin
      n_fail++;
      $display("FAIL rm_reset grant=%b busy=%b cnt=%0d done=%b id=%0d required all zero",
               bus.grant, bus.busy, bus.cnt_out, bus.done, bus.done_id);
    end
    reset   = 1'b0;
    bus.req = 4'b0110;
    tick();
    n_tests++;
    if (bus.grant !== 4'b0010 || bus.done !== 1'b0 || bus.cnt_out !== 5'd4) begin
      n_fail++;
      $display("FAIL rm_next grant=%b done=%b cnt=%0d required grant=0010 done=0 cnt=4",
               bus.grant, bus.done, bus.cnt_out);
    end
    bus.req = '0;
  endtask

  task automatic test_abort();
    do_reset();
    set_len(0, 5'd10);
    bus.req = 4'b0001;
    for (int c = 0; c < 5; c++) tick();
    n_tests++;
    if (bus.cnt_out !== 5'd6 || bus.grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL ab_pre cnt=%0d grant=%b required cnt=6 grant=0001", bus.cnt_out, bus.grant);
    end
    bus.req = '0;
    tick();
`ifdef SLOT_ARB_ABORT_EN
    n_tests++;
    if (bus.done !== 1'b1 || bus.aborted !== 1'b1 || bus.cnt_out !== 5'd6 || bus.grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL ab_abort done=%b aborted=%b cnt=%0d grant=%b required done=1 aborted=1 cnt=6 grant=0000",
               bus.done, bus.aborted, bus.cnt_out, bus.grant);
    end
`else
    for (int c = 5; c >= 0; c--) begin
      n_tests++;
      if (bus.cnt_out !== 5'(c) || bus.grant !== 4'b0001 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL ab_norun cnt=%0d grant=%b done=%b required cnt=%0d grant=0001 done=0",
                 bus.cnt_out, bus.grant, bus.done, c);
      end
      tick();
    end
    n_tests++;
    if (bus.done !== 1'b1 || bus.done_id !== 2'd0 || bus.cnt_out !== 5'd0 || bus.grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL ab_nodone done=%b id=%0d cnt=%0d grant=%b required done=1 id=0 cnt=0 grant=0000",
               bus.done, bus.done_id, bus.cnt_out, bus.grant);
    end
`endif
  endtask

  task automatic test_random();
    reset   = 1'b1;
    bus.req = '0;
    for (int c = 0; c < 2; c++) begin
      m_step();
      tick();
    end
    reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) bus.req[i] = ~bus.req[i];
      if ($urandom_range(3) == 0) set_len($urandom_range(N - 1), 5'($urandom_range(9)));
      reset = ($urandom_range(149) == 0);
      m_step();
      tick();
      n_tests++;
      if (bus.grant !== m_grant || bus.busy !== m_busy || bus.cnt_out !== m_cnt || bus.done !== m_done) begin
        n_fail++;
        $display("FAIL rand_out cyc=%0d grant=%b busy=%b cnt=%0d done=%b required grant=%b busy=%b cnt=%0d done=%b",
                 c, bus.grant, bus.busy, bus.cnt_out, bus.done, m_grant, m_busy, m_cnt, m_done);
      end
      if (m_done) begin
        n_tests++;
        if (bus.done_id !== m_did) begin
          n_fail++;
          $display("FAIL rand_id cyc=%0d done_id=%0d required %0d", c, bus.done_id, m_did);
        end
      end
`ifdef SLOT_ARB_ABORT_EN
      n_tests++;
      if (bus.aborted !== m_ab) begin
        n_fail++;
        $display("FAIL rand_abort cyc=%0d aborted=%b required %b", c, bus.aborted, m_ab);
      end
`endif
      n_tests++;
      if (!$onehot0(bus.grant)) begin
        n_fail++;
        $display("FAIL rand_onehot cyc=%0d grant=%b required zero- or one-hot", c, bus.grant);
      end
    end
    reset   = 1'b0;
    bus.req = '0;
  endtask

  initial begin
    reset   = 1'b1;
    bus.req = '0;
    bus.len = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_wrap();
    test_reset_mid();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/slot_timer_arbiter.md
Name: slot_timer_arbiter

Overview:
- Shares one 5-bit down counter, the team's standard countdown datapath, between NUM_REQ requesters as a time-slot resource.
- Grants the counter to one requester at a time, chosen round-robin.
- Loads the winner's requested slot length, counts the counter down to 0, then signals completion and rotates priority.
- Sits between requesting engines and the shared countdown datapath. Acts as both scheduler and controller of that datapath.

Parameters:
- NUM_REQ, default 4: number of requesters (2..8).
- CNT_W, default 5: counter and slot-length width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester slot request, level-sensitive.
- len  in  NUM_REQ*CNT_W  slot length per requester; requester i uses bits [i*CNT_W +: CNT_W].
- grant  out  NUM_REQ  one-hot grant, registered.
- busy  out  1  high while a slot is active (state RUN).
- cnt_out  out  CNT_W  current counter value.
- done  out  1  one-cycle pulse at slot completion.
- done_id  out  $clog2(NUM_REQ)  index of the requester whose slot just completed; valid with done.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on the reset port.
- Reset values: state=IDLE, grant=0, busy=0, cnt_out=0, done=0, done_id=0, rr_ptr=0.
- FSM IDLE:
  - If any req bit is set, select the first set bit searching upward from rr_ptr, with wrap-around.
  - Next cycle: state=RUN, grant=onehot(winner), cnt_out=len[winner] (sampled in this IDLE cycle), busy=1.
  - If no req bit is set, stay in IDLE with outputs idle.
- FSM RUN:
  - If cnt_out != 0: decrement by 1 each cycle.
  - If cnt_out == 0: next state=DONE.
  - grant and busy stay high throughout RUN.
  - Grant duration is exactly len+1 cycles. len=0 gives a single RUN cycle.
- FSM DONE, one cycle:
  - done=1, done_id=winner, grant=0, busy=0, cnt_out holds 0.
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - Next state=IDLE.
- Request-to-grant latency: 1 cycle.
- Minimum gap between consecutive grants: 2 cycles (DONE, then IDLE).
- Changes to len during RUN are ignored. Changes to req during RUN are ignored unless the optional feature is compiled in.
- Round-robin fairness: with all requesters constantly requesting, grant order is 0,1,2,3,0,...
- Reset asserted in any state returns everything to reset values on the next edge. No done pulse is produced for the aborted slot.
- The counter never wraps. No decrement happens below 0.
- grant is always zero-hot or one-hot.

Optional Feature:
- Macro: SLOT_ARB_ABORT_EN.
- Defined:
  - In RUN, if req[winner]==0, the next state is DONE regardless of cnt_out, and cnt_out freezes at its current value.
  - In that DONE cycle an extra output, aborted (1 bit, reset 0), pulses high alongside done.
  - aborted=0 on normal completion.
- Undefined:
  - The aborted port is absent.
  - Deassertion of req during RUN is ignored; the slot always runs its full length.

Decomposition:
- Package slot_arb_pkg holds:
  - typedef enum state_t {IDLE, RUN, DONE}
  - localparam CNT_W_DEFAULT=5
  - function rr_pick(req, ptr), returning the winner index.
- Sub-module loadable_down_counter:
  - Ports: clk, reset, load, load_val, en, out, zero.
  - Loadable, enable-gated, saturating-at-0 version of the team's down counter.
  - Instantiated once; the arbiter drives load in IDLE-to-RUN and en in RUN.

Test Plan:
- Reset then idle: reset for 2 cycles, req=0 for 10 cycles -> grant=0, busy=0, cnt_out=0, done never pulses.
- Single slot: req=4'b0010, len[1]=3 -> grant=4'b0010 the cycle after req; cnt_out sequence 3,2,1,0; done=1 with done_id=1 on the following cycle; grant held for exactly 4 cycles.
- Round-robin: req=4'b1111, all len=1 -> done_id sequence 0,1,2,3,0; each grant lasts 2 cycles; 2-cycle gaps between grants.
- Zero length and wrap: rr_ptr=3 after serving requester 2; req=4'b1001, len[3]=0 -> requester 3 is granted for 1 cycle, then done; requester 0 is served next.
- Reset mid-slot: len[2]=20, reset asserted at cnt_out=12 -> next cycle all outputs are at reset values, no done pulse, and the next grant goes to the lowest requester.
- Abort (SLOT_ARB_ABORT_EN defined): len[0]=10, req[0] dropped at cnt_out=6 -> next cycle done=1 and aborted=1, cnt_out=6, grant=0. Without the macro, the same stimulus runs to cnt_out=0 and done pulses with no abort.
